// File: rtl/sobol_stream.sv
// Sequencer and output register around a combinational Sobol point generator.
// Walks paths start_index.. and dimensions 0..M-1, emitting one sample per cycle on a valid/ready stream.
module sobol_stream #(
    parameter int M     = 50,
    parameter int DIM_W = $clog2(M)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      start_index,
    input  logic [31:0]      num_paths,
    output logic             busy,
    output logic             done,
    output logic [31:0]      sobol_n,
    output logic [DIM_W-1:0] sobol_dim,
    input  logic [31:0]      sobol_in,
    output logic             u_valid,
    input  logic             u_ready,
    output logic [31:0]      u_data,
    output logic [DIM_W-1:0] u_dim,
    output logic [31:0]      u_path,
    output logic             u_last,
    output logic             u_final
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [DIM_W-1:0] DIM_LAST = DIM_W'(M - 1);

    state_t           state_q, state_d;
    logic [31:0]      n_q, n_d;
    logic [DIM_W-1:0] dim_q, dim_d;
    logic [31:0]      rem_q, rem_d;
    logic             u_valid_q, u_valid_d;
    logic [31:0]      u_data_q, u_data_d;
    logic [DIM_W-1:0] u_dim_q, u_dim_d;
    logic [31:0]      u_path_q, u_path_d;
    logic             u_last_q, u_last_d;
    logic             u_final_q, u_final_d;
    logic             done_q, done_d;
    logic             issue;
    logic             is_last;
    logic             is_final;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        dim_d     = dim_q;
        rem_d     = rem_q;
        u_valid_d = u_valid_q;
        u_data_d  = u_data_q;
        u_dim_d   = u_dim_q;
        u_path_d  = u_path_q;
        u_last_d  = u_last_q;
        u_final_d = u_final_q;
        done_d    = 1'b0;
        issue     = !u_valid_q || u_ready;
        is_last   = (dim_q == DIM_LAST);
        is_final  = is_last && (rem_q == 32'd1);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_paths != 32'd0) begin
                        n_d     = start_index;
                        dim_d   = '0;
                        rem_d   = num_paths;
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    u_data_d  = sobol_in;
                    u_dim_d   = dim_q;
                    u_path_d  = n_q;
                    u_valid_d = 1'b1;
                    u_last_d  = is_last;
                    u_final_d = is_final;
                    if (is_final) begin
                        state_d = DRAIN;
                    end else if (!is_last) begin
                        dim_d = dim_q + 1'b1;
                    end else begin
                        // Path index wraps modulo 2^32 by design.
                        dim_d = '0;
                        n_d   = n_q + 32'd1;
                        rem_d = rem_q - 32'd1;
                    end
                end
            end
            DRAIN: begin
                if (u_valid_q && u_ready) begin
                    u_valid_d = 1'b0;
                    u_last_d  = 1'b0;
                    u_final_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            n_q       <= '0;
            dim_q     <= '0;
            rem_q     <= '0;
            u_valid_q <= 1'b0;
            u_data_q  <= '0;
            u_dim_q   <= '0;
            u_path_q  <= '0;
            u_last_q  <= 1'b0;
            u_final_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            dim_q     <= dim_d;
            rem_q     <= rem_d;
            u_valid_q <= u_valid_d;
            u_data_q  <= u_data_d;
            u_dim_q   <= u_dim_d;
            u_path_q  <= u_path_d;
            u_last_q  <= u_last_d;
            u_final_q <= u_final_d;
            done_q    <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign sobol_n   = n_q;
    assign sobol_dim = dim_q;
    assign u_valid   = u_valid_q;
    assign u_data    = u_data_q;
    assign u_dim     = u_dim_q;
    assign u_path    = u_path_q;
    assign u_last    = u_last_q;
    assign u_final   = u_final_q;

endmodule

// File: tb/tb_sobol_stream.sv
// Directed bench for sobol_stream with M=4 and a behavioural gray-code Sobol generator on sobol_in.
module tb_sobol_stream;

    localparam int M  = 4;
    localparam int DW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [31:0]   start_index;
    logic [31:0]   num_paths;
    logic          busy;
    logic          done;
    logic [31:0]   sobol_n;
    logic [DW-1:0] sobol_dim;
    logic [31:0]   sobol_in;
    logic          u_valid;
    logic          u_ready;
    logic [31:0]   u_data;
    logic [DW-1:0] u_dim;
    logic [31:0]   u_path;
    logic          u_last;
    logic          u_final;

    int checks = 0;
    int errors = 0;
    logic [31:0] d0q[$];

    always #5 clk = ~clk;

    sobol_stream #(.M(M), .DIM_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_index(start_index),
        .num_paths(num_paths), .busy(busy), .done(done), .sobol_n(sobol_n),
        .sobol_dim(sobol_dim), .sobol_in(sobol_in), .u_valid(u_valid),
        .u_ready(u_ready), .u_data(u_data), .u_dim(u_dim), .u_path(u_path),
        .u_last(u_last), .u_final(u_final)
    );

    // Sobol point with gray-code ordering; direction numbers for the first four dimensions.
    function automatic logic [31:0] sob(input logic [31:0] n, input int d);
        logic [31:0] v[1:32];
        logic [31:0] g;
        logic [31:0] x;
        for (int k = 1; k <= 32; k++) begin
            case (d)
                0: v[k] = 32'h8000_0000 >> (k - 1);
                1: v[k] = (k == 1) ? 32'h8000_0000 : (v[k-1] ^ (v[k-1] >> 1));
                2: begin
                    if (k == 1)      v[k] = 32'h8000_0000;
                    else if (k == 2) v[k] = 32'hC000_0000;
                    else             v[k] = v[k-2] ^ (v[k-2] >> 2) ^ v[k-1];
                end
                default: begin
                    if (k == 1)      v[k] = 32'h8000_0000;
                    else if (k == 2) v[k] = 32'hC000_0000;
                    else if (k == 3) v[k] = 32'h2000_0000;
                    else             v[k] = v[k-2] ^ v[k-3] ^ (v[k-3] >> 3);
                end
            endcase
        end
        g = n ^ (n >> 1);
        x = '0;
        for (int k = 0; k < 32; k++)
            if (g[k]) x = x ^ v[k+1];
        return x;
    endfunction

    assign sobol_in = sob(sobol_n, int'(sobol_dim));

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] samp_vec();
        return {u_valid, u_data, u_dim, u_path, u_last, u_final};
    endfunction

    // One job: start pulse, collect samples, check payload/hold/done; poke>0 pulses start mid-job.
    task automatic run_job(input logic [31:0] si, input logic [31:0] np, input bit stall,
                           input int poke, input int exp_done);
        int total, budget, nxfer, ndone, first_v, done_cyc;
        bit prev_stall;
        logic [127:0] held;
        logic [31:0] path_e;
        logic [DW-1:0] dim_e;
        d0q.delete();
        @(negedge clk);
        start = 1'b1; start_index = si; num_paths = np; u_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        total = int'(np) * M;
        budget = total * 4 + 20;
        nxfer = 0; ndone = 0; first_v = -1; done_cyc = -1; prev_stall = 0; held = '0;
        if (np != 0) chk("busy_run", busy, 1'b1);
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (prev_stall) chk("hold", samp_vec(), held);
            if (u_valid && first_v < 0) first_v = cyc;
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
                chk("busy_at_done", busy, 1'b0);
            end
            start = (cyc == poke);
            if (cyc == poke) begin start_index = 32'd99; num_paths = 32'd5; end
            u_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (u_valid && u_ready) begin
                path_e = si + 32'(nxfer / M);
                dim_e  = DW'(nxfer % M);
                chk("sample", {u_data, u_dim, u_path, u_last, u_final},
                    {sob(path_e, int'(dim_e)), dim_e, path_e, (dim_e == DW'(M - 1)), (nxfer == total - 1)});
                if (u_dim == '0) d0q.push_back(u_data);
                nxfer++;
            end
            prev_stall = u_valid && !u_ready;
            held = samp_vec();
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        u_ready = 1'b1;
        chk("xfer_count", nxfer, total);
        chk("done_count", ndone, 1);
        if (exp_done > 0) chk("done_cycle", done_cyc, exp_done);
        if (np == 0) chk("no_valid", first_v, -1);
        else if (!stall) chk("first_valid_cycle", first_v, 2);
    endtask

    typedef struct {
        logic [31:0] si;
        logic [31:0] np;
        bit          stall;
        int          poke;
        int          exp_done;
        logic [31:0] exp_d0;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{32'd1,          32'd1, 1'b0, 0, 6,  32'h8000_0000};
        tbl[1] = '{32'd1,          32'd3, 1'b1, 0, 0,  32'h8000_0000};
        tbl[2] = '{32'hFFFF_FFFF,  32'd2, 1'b0, 0, 10, 32'h0000_0001};
        tbl[3] = '{32'd0,          32'd1, 1'b0, 0, 6,  32'h0000_0000};
        tbl[4] = '{32'd5,          32'd2, 1'b1, 0, 0,  32'hE000_0000};
        tbl[5] = '{32'd0,          32'd0, 1'b0, 0, 1,  32'h0000_0000};
        tbl[6] = '{32'd1,          32'd2, 1'b0, 3, 10, 32'h8000_0000};

        rst_n = 1'b0; start = 1'b0; start_index = '0; num_paths = '0; u_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {busy, done, sobol_n, sobol_dim, samp_vec()}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_job(tbl[i].si, tbl[i].np, tbl[i].stall, tbl[i].poke, tbl[i].exp_done);
            if (tbl[i].np != 0) chk($sformatf("d0_first_%0d", i), d0q.size() > 0 ? d0q[0] : 32'hDEAD_BEEF, tbl[i].exp_d0);
        end

        run_job(32'd1, 32'd3, 1'b0, 0, 14);
        chk("d0_seq", {d0q.size() == 3 ? {d0q[0], d0q[1], d0q[2]} : 96'h0},
            {32'h8000_0000, 32'hC000_0000, 32'h4000_0000});

        // Reset in the middle of a job with a sample pending.
        @(negedge clk);
        start = 1'b1; start_index = 32'd1; num_paths = 32'd3; u_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("valid_before_reset", u_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_reset", {busy, done, sobol_n, sobol_dim, samp_vec()}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        u_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_after_reset", {busy, done, u_valid}, 3'b000);
        end
        run_job(32'd1, 32'd1, 1'b0, 0, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
